multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle build of the MIPS core. It sequences one shared ALU, memory port, register file and PC across several cycles per instruction. It decodes the 6-bit opcode into per-state control strobes and drives the 2-bit ALUOp consumed by ALU_Decoder. Per-state memory accesses stall on a ready handshake.

---
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS core: sequences the shared ALU,
// memory port, register file and PC, with ready-handshake stalls on memory states.
module multicycle_controller #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t r_state;
    state_t w_next;
    logic   w_rdy;
    logic   w_memwrite, w_irwrite, w_pcwrite, w_branch, w_illegal;

    assign w_rdy = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        case (r_state)
            FETCH: begin
                ALUSrcB   = 2'b01;
                w_irwrite = w_rdy;
                w_pcwrite = w_rdy;
                if (w_rdy) w_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYP:      w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Op changing to something else here would be an IR fault; drop to FETCH.
                if (Op == OP_LW)      w_next = MEMRD;
                else if (Op == OP_SW) w_next = MEMWR;
                else                  w_next = FETCH;
            end
            MEMRD: begin
                IorD = 1'b1;
                if (w_rdy) w_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                w_next   = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = w_rdy;
                if (w_rdy) w_next = FETCH;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                w_next   = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
                w_next   = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                w_next   = FETCH;
            end
            JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    // Strobes are suppressed while reset is held so nothing commits during reset.
    assign MemWrite = w_memwrite & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign PCWrite  = w_pcwrite  & ~reset;
    assign Branch   = w_branch   & ~reset;
    assign Illegal  = w_illegal  & ~reset;
    assign PCEn     = PCWrite | (Branch & Zero);
    assign State    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// go through a scoreboard queue and are compared mid-cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       MemWrite, IRWrite, PCWrite, Branch, PCEn, IorD, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [20:0] vec;
    } exp_t;
    exp_t sb[$];

    multicycle_controller #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .PCEn(PCEn), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    // Vector layout: State, MemWrite, IRWrite, PCWrite, Branch, PCEn, IorD, RegDst,
    // MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal
    function automatic logic [20:0] exp_vec(input int st, input logic [5:0] op,
                                            input logic z, input logic rdy, input logic rst);
        logic mw, irw, pcw, br, iord, rd, m2r, rw, sa, ill;
        logic [1:0] sb2, aop, pcs;
        {mw, irw, pcw, br, iord, rd, m2r, rw, sa, ill} = '0;
        sb2 = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin sb2 = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin
                    sb2 = 2'b11;
                    ill = !(op inside {6'b100011, 6'b101011, 6'b000000,
                                       6'b000100, 6'b001000, 6'b000010});
                end
            2:  begin sa = 1; sb2 = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = rdy; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            9:  begin sa = 1; sb2 = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) {mw, irw, pcw, br, ill} = '0;
        return {st[3:0], mw, irw, pcw, br, pcw | (br & z), iord, rd, m2r, rw, sa,
                sb2, aop, pcs, ill};
    endfunction

    // One clock cycle: drive at negedge, push expectation, sample 2ns later.
    task automatic cyc(input string tag, input int st, input logic [5:0] op,
                       input logic z, input logic rdy, input logic rst);
        exp_t e;
        logic [20:0] obs;
        @(negedge clk);
        reset = rst; Op = op; Zero = z; MemReady = rdy;
        sb.push_back('{tag, exp_vec(st, op, z, rdy, rst)});
        #2;
        obs = {State, MemWrite, IRWrite, PCWrite, Branch, PCEn, IorD, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal};
        e = sb.pop_front();
        n_vec++;
        assert (obs === e.vec) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    initial begin
        reset = 1'b1; Op = 6'b0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        cyc("reset_hold",  0, RT, 1'b1, 1'b1, 1'b1);
        // lw, no waits; Op scrambled where it must be ignored
        cyc("lw_fetch",    0, BAD, 1'b0, 1'b1, 1'b0);
        cyc("lw_decode",   1, LW,  1'b0, 1'b0, 1'b0);
        cyc("lw_memadr",   2, LW,  1'b0, 1'b0, 1'b0);
        cyc("lw_memrd",    3, SW,  1'b0, 1'b1, 1'b0);
        cyc("lw_memwb",    4, BAD, 1'b1, 1'b0, 1'b0);
        // sw with two wait cycles
        cyc("sw_fetch",    0, SW,  1'b0, 1'b1, 1'b0);
        cyc("sw_decode",   1, SW,  1'b0, 1'b1, 1'b0);
        cyc("sw_memadr",   2, SW,  1'b0, 1'b1, 1'b0);
        cyc("sw_wait1",    5, LW,  1'b0, 1'b0, 1'b0);
        cyc("sw_wait2",    5, SW,  1'b0, 1'b0, 1'b0);
        cyc("sw_write",    5, SW,  1'b0, 1'b1, 1'b0);
        // R-type then addi
        cyc("rt_fetch",    0, RT,  1'b0, 1'b1, 1'b0);
        cyc("rt_decode",   1, RT,  1'b0, 1'b0, 1'b0);
        cyc("rt_execute",  6, J,   1'b0, 1'b0, 1'b0);
        cyc("rt_aluwb",    7, BAD, 1'b0, 1'b1, 1'b0);
        cyc("addi_fetch",  0, ADDI, 1'b0, 1'b1, 1'b0);
        cyc("addi_decode", 1, ADDI, 1'b0, 1'b1, 1'b0);
        cyc("addi_ex",     9, ADDI, 1'b0, 1'b1, 1'b0);
        cyc("addi_wb",    10, ADDI, 1'b0, 1'b1, 1'b0);
        // beq taken then not taken
        cyc("beq1_fetch",  0, BEQ, 1'b0, 1'b1, 1'b0);
        cyc("beq1_decode", 1, BEQ, 1'b0, 1'b1, 1'b0);
        cyc("beq1_taken",  8, BEQ, 1'b1, 1'b1, 1'b0);
        cyc("beq2_fetch",  0, BEQ, 1'b1, 1'b1, 1'b0);
        cyc("beq2_decode", 1, BEQ, 1'b1, 1'b1, 1'b0);
        cyc("beq2_nottkn", 8, BEQ, 1'b0, 1'b1, 1'b0);
        // illegal opcode then jump
        cyc("ill_fetch",   0, BAD, 1'b0, 1'b1, 1'b0);
        cyc("ill_decode",  1, BAD, 1'b0, 1'b1, 1'b0);
        cyc("j_fetch",     0, J,   1'b0, 1'b1, 1'b0);
        cyc("j_decode",    1, J,   1'b0, 1'b1, 1'b0);
        cyc("j_jump",     11, J,   1'b0, 1'b1, 1'b0);
        // fetch stall
        cyc("fetch_stall", 0, RT,  1'b0, 1'b0, 1'b0);
        cyc("fetch_go",    0, RT,  1'b0, 1'b1, 1'b0);
        cyc("rt2_decode",  1, LW,  1'b0, 1'b1, 1'b0);
        // reset in the middle of a MEMRD stall
        cyc("rs_memadr",   2, LW,  1'b0, 1'b1, 1'b0);
        cyc("rs_stall",    3, LW,  1'b0, 1'b0, 1'b0);
        cyc("rs_assert",   3, LW,  1'b0, 1'b0, 1'b1);
        cyc("rs_held",     0, LW,  1'b0, 1'b1, 1'b1);
        cyc("rs_release",  0, J,   1'b0, 1'b1, 1'b0);
        cyc("rs_decode",   1, J,   1'b0, 1'b1, 1'b0);
        cyc("rs_jump",    11, J,   1'b1, 1'b1, 1'b0);
        cyc("rs_back",     0, J,   1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
